// File: rtl/reg_write_arbiter_if.sv
// Bundle of the WB/MD result buses, decode-stage hazard lookups and the
// reg_file write port that reg_write_arbiter sits between.
interface reg_write_arbiter_if;
    logic        WB_VALID;
    logic [4:0]  WB_ADDRESS;
    logic [31:0] WB_DATA;
    logic        MD_ISSUE;
    logic [4:0]  MD_ISSUE_ADDRESS;
    logic        MD_VALID;
    logic [4:0]  MD_ADDRESS;
    logic [31:0] MD_DATA;
    logic        MD_READY;
    logic [4:0]  RS1_ADDRESS;
    logic [4:0]  RS2_ADDRESS;
    logic        RS1_BUSY;
    logic        RS2_BUSY;
    logic        STALL_PIPE;
    logic        WRITE_ENABLE;
    logic [4:0]  WRITE_ADDRESS;
    logic [31:0] WRITE_DATA;

    // Pipeline side: drives results, issues and source lookups.
    modport master (
        output WB_VALID, WB_ADDRESS, WB_DATA,
        output MD_ISSUE, MD_ISSUE_ADDRESS,
        output MD_VALID, MD_ADDRESS, MD_DATA,
        output RS1_ADDRESS, RS2_ADDRESS,
        input  MD_READY, RS1_BUSY, RS2_BUSY, STALL_PIPE,
        input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
    );

    // Arbiter side.
    modport slave (
        input  WB_VALID, WB_ADDRESS, WB_DATA,
        input  MD_ISSUE, MD_ISSUE_ADDRESS,
        input  MD_VALID, MD_ADDRESS, MD_DATA,
        input  RS1_ADDRESS, RS2_ADDRESS,
        output MD_READY, RS1_BUSY, RS2_BUSY, STALL_PIPE,
        output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the single reg_file write port between writeback (never stalls) and
// the multiply/divide unit (waits). A one-entry hold buffer and a forced
// one-cycle pipeline stall bound how long MD can be starved. A pending bit per
// register tracks MD destinations not yet written back, for hazard detection.
module reg_write_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input logic               CLK,
    input logic               RESET,
    reg_write_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIMIT_4 = 4'(STARVE_LIMIT);

    logic        write_enable_reg;
    logic [4:0]  write_address_reg;
    logic [31:0] write_data_reg;
    logic        write_from_md_reg;
    logic        hold_valid_reg;
    logic [4:0]  hold_address_reg;
    logic [31:0] hold_data_reg;
    logic [3:0]  starve_count_reg;
    logic        stall_reg;
    logic [31:1] pending_reg;

    logic        wb_live;
    logic        md_accept;
    logic        grant_hold;
    logic        grant_wb;
    logic        grant_md;
    logic        capture_hold;
    logic [4:0]  write_address_next;
    logic [31:0] write_data_next;
    logic [3:0]  starve_count_next;
    logic        stall_next;
    logic [31:0] pending_map;

    // WB writes to x0 are ignored entirely and never compete for the port.
    assign wb_live = bus.WB_VALID && (bus.WB_ADDRESS != 5'd0);

    // MD wins the port during a stall, when WB is idle, or when its result is
    // headed for x0 and will simply be discarded. The hold buffer blocks MD.
    assign md_accept = !hold_valid_reg && bus.MD_VALID &&
                       (stall_reg || !wb_live || (bus.MD_ADDRESS == 5'd0));
    assign bus.MD_READY = md_accept;

    // Pick the source for the write port: hold, then MD on stall, then WB, then MD.
    always_comb begin
        grant_hold         = hold_valid_reg;
        grant_md           = md_accept && (bus.MD_ADDRESS != 5'd0);
        grant_wb           = !hold_valid_reg && !stall_reg && wb_live;
        capture_hold       = !hold_valid_reg && stall_reg && wb_live;
        write_address_next = bus.WB_ADDRESS;
        write_data_next    = bus.WB_DATA;
        if (grant_hold) begin
            write_address_next = hold_address_reg;
            write_data_next    = hold_data_reg;
        end else if (grant_md) begin
            write_address_next = bus.MD_ADDRESS;
            write_data_next    = bus.MD_DATA;
        end
    end

    // Count consecutive lost cycles for a waiting MD result; stall once it reaches the limit.
    always_comb begin
        starve_count_next = 4'd0;
        stall_next        = 1'b0;
        if (bus.MD_VALID && !md_accept) begin
            starve_count_next = (starve_count_reg == 4'hF) ? 4'hF : starve_count_reg + 4'd1;
            stall_next        = (starve_count_next >= STARVE_LIMIT_4);
        end
    end

    // Write port, hold buffer and starvation state; reset drops anything in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            write_enable_reg  <= 1'b0;
            write_address_reg <= 5'd0;
            write_data_reg    <= 32'd0;
            write_from_md_reg <= 1'b0;
            hold_valid_reg    <= 1'b0;
            hold_address_reg  <= 5'd0;
            hold_data_reg     <= 32'd0;
            starve_count_reg  <= 4'd0;
            stall_reg         <= 1'b0;
        end else begin
            write_enable_reg  <= grant_hold || grant_wb || grant_md;
            write_from_md_reg <= grant_md && !grant_hold;
            if (grant_hold || grant_wb || grant_md) begin
                write_address_reg <= write_address_next;
                write_data_reg    <= write_data_next;
            end
            hold_valid_reg <= capture_hold;
            if (capture_hold) begin
                hold_address_reg <= bus.WB_ADDRESS;
                hold_data_reg    <= bus.WB_DATA;
            end
            starve_count_reg <= starve_count_next;
            stall_reg        <= stall_next;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_pending
            // Set on MD issue, clear when the MD write commits; a same-edge re-issue wins.
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    pending_reg[gi] <= 1'b0;
                end else if (bus.MD_ISSUE && (bus.MD_ISSUE_ADDRESS == 5'(gi))) begin
                    pending_reg[gi] <= 1'b1;
                end else if (write_enable_reg && write_from_md_reg &&
                             (write_address_reg == 5'(gi))) begin
                    pending_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // x0 has no pending bit, so it always reads as not busy.
    assign pending_map   = {pending_reg, 1'b0};
    assign bus.RS1_BUSY  = pending_map[bus.RS1_ADDRESS];
    assign bus.RS2_BUSY  = pending_map[bus.RS2_ADDRESS];

    assign bus.STALL_PIPE    = stall_reg;
    assign bus.WRITE_ENABLE  = write_enable_reg;
    assign bus.WRITE_ADDRESS = write_address_reg;
    assign bus.WRITE_DATA    = write_data_reg;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: a reference model predicts the ordered stream of
// register writes, MD acceptance, stall and busy flags; a monitor compares
// every write the DUT presents against the predicted stream.
module tb_reg_write_arbiter;
    localparam int LIMIT = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t exp_q[$];

    // Reference model state.
    bit          m_stall;
    bit          m_hold_v;
    wr_t         m_hold;
    int          m_wait;
    bit          pend[32];
    int          clr_addr;
    bit          prev_stall;

    // MD unit as seen from outside: one result, held until accepted.
    bit          md_v;
    logic [4:0]  md_a;
    logic [31:0] md_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_stall    = 1'b0;
        m_hold_v   = 1'b0;
        m_wait     = 0;
        clr_addr   = -1;
        prev_stall = 1'b0;
        md_v       = 1'b0;
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic apply_cycle(input bit wbv, input logic [4:0] wba, input logic [31:0] wbd,
                               input bit md_start, input logic [4:0] mda, input logic [31:0] mdd,
                               input bit iss, input logic [4:0] ia,
                               input logic [4:0] r1, input logic [4:0] r2);
        bit  wb_eff, wb_real, exp_ready, new_hold_v, new_stall;
        int  next_clr;
        wr_t w;
        @(negedge CLK);
        if (md_start && !md_v) begin
            md_v = 1'b1;
            md_a = mda;
            md_d = mdd;
        end
        wb_eff = wbv && !prev_stall;
        bus.WB_VALID         = wb_eff;
        bus.WB_ADDRESS       = wba;
        bus.WB_DATA          = wbd;
        bus.MD_VALID         = md_v;
        bus.MD_ADDRESS       = md_a;
        bus.MD_DATA          = md_d;
        bus.MD_ISSUE         = iss;
        bus.MD_ISSUE_ADDRESS = ia;
        bus.RS1_ADDRESS      = r1;
        bus.RS2_ADDRESS      = r2;
        #1;
        wb_real   = wb_eff && (wba != 5'd0);
        exp_ready = !m_hold_v && md_v && (m_stall || !wb_real || md_a == 5'd0);
        check("md_ready", 32'(bus.MD_READY), 32'(exp_ready));
        check("stall_pipe", 32'(bus.STALL_PIPE), 32'(m_stall));
        check("rs1_busy", 32'(bus.RS1_BUSY), 32'(pend[r1]));
        check("rs2_busy", 32'(bus.RS2_BUSY), 32'(pend[r2]));
        $display("cyc wb=%0b x%0d=%0h md=%0b x%0d=%0h rdy=%0b stall=%0b iss=%0b x%0d",
                 wb_eff, wba, wbd, md_v, md_a, md_d, bus.MD_READY, bus.STALL_PIPE, iss, ia);

        // Which results reach the port at this edge, in priority order.
        new_hold_v = 1'b0;
        next_clr   = -1;
        if (m_hold_v) begin
            exp_q.push_back(m_hold);
        end else if (m_stall) begin
            if (md_v && md_a != 5'd0) begin
                w.addr = md_a; w.data = md_d; exp_q.push_back(w);
                next_clr = int'(md_a);
            end
            if (wb_real) begin
                new_hold_v = 1'b1;
                m_hold.addr = wba;
                m_hold.data = wbd;
            end
        end else if (wb_real) begin
            w.addr = wba; w.data = wbd; exp_q.push_back(w);
        end else if (md_v && md_a != 5'd0) begin
            w.addr = md_a; w.data = md_d; exp_q.push_back(w);
            next_clr = int'(md_a);
        end

        // Starvation: count cycles MD waited; stall once the count reaches the limit.
        if (md_v && !exp_ready) begin
            m_wait    = (m_wait < 15) ? m_wait + 1 : 15;
            new_stall = (m_wait >= LIMIT);
        end else begin
            m_wait    = 0;
            new_stall = 1'b0;
        end

        // Pending bits: MD write committed this edge clears, issue sets (set wins).
        if (clr_addr > 0) pend[clr_addr] = 1'b0;
        if (iss && ia != 5'd0) pend[ia] = 1'b1;
        clr_addr = next_clr;

        if (exp_ready) md_v = 1'b0;
        prev_stall = m_stall;
        m_stall    = new_stall;
        m_hold_v   = new_hold_v;
    endtask

    task automatic idle(input logic [4:0] r1);
        apply_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, 5'd0);
    endtask

    task automatic random_cycle(input int wb_pct);
        apply_cycle($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 99) < 40,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
                    $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    task automatic check_reset_outputs();
        check("rst_write_enable", 32'(bus.WRITE_ENABLE), 32'd0);
        check("rst_write_address", 32'(bus.WRITE_ADDRESS), 32'd0);
        check("rst_write_data", bus.WRITE_DATA, 32'd0);
        check("rst_stall_pipe", 32'(bus.STALL_PIPE), 32'd0);
        check("rst_md_ready", 32'(bus.MD_READY), 32'd0);
        check("rst_rs1_busy", 32'(bus.RS1_BUSY), 32'd0);
    endtask

    // Monitor: every write the DUT presents must be the next predicted one.
    initial begin
        wr_t w;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET && bus.WRITE_ENABLE) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got x%0d=%0h, expected no write (t=%0t)",
                             bus.WRITE_ADDRESS, bus.WRITE_DATA, $time);
                end else begin
                    w = exp_q.pop_front();
                    $display("write x%0d=%0h (expected x%0d=%0h)", bus.WRITE_ADDRESS,
                             bus.WRITE_DATA, w.addr, w.data);
                    check("write_address", 32'(bus.WRITE_ADDRESS), 32'(w.addr));
                    check("write_data", bus.WRITE_DATA, w.data);
                end
            end
        end
    end

    initial begin
        model_clear();
        md_a = 5'd0;
        md_d = 32'd0;
        bus.WB_VALID = 1'b0; bus.WB_ADDRESS = 5'd0; bus.WB_DATA = 32'd0;
        bus.MD_ISSUE = 1'b0; bus.MD_ISSUE_ADDRESS = 5'd0;
        bus.MD_VALID = 1'b0; bus.MD_ADDRESS = 5'd0; bus.MD_DATA = 32'd0;
        bus.RS1_ADDRESS = 5'd0; bus.RS2_ADDRESS = 5'd0;

        // Reset values.
        repeat (2) @(negedge CLK);
        #1;
        check_reset_outputs();
        @(negedge CLK);
        RESET = 1'b1;

        // WB x1=10, then an idle cycle watching x1.
        apply_cycle(1'b1, 5'd1, 32'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd0);
        idle(5'd1);
        // Contention: WB x2=5 and MD x3=7 together; WB first, MD next.
        apply_cycle(1'b1, 5'd2, 32'd5, 1'b1, 5'd3, 32'd7, 1'b0, 5'd0, 5'd3, 5'd2);
        idle(5'd3);
        idle(5'd0);
        // Starvation: MD x4=99 against WB x5, x6, x7 on consecutive cycles.
        apply_cycle(1'b1, 5'd5, 32'd1, 1'b1, 5'd4, 32'd99, 1'b0, 5'd0, 5'd4, 5'd5);
        apply_cycle(1'b1, 5'd6, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6);
        apply_cycle(1'b1, 5'd7, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd7);
        idle(5'd7);
        idle(5'd0);
        // Scoreboard: issue x6, result accepted, re-issue on the clearing edge.
        apply_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd0);
        apply_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'd123, 1'b0, 5'd0, 5'd6, 5'd6);
        apply_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd6);
        idle(5'd6);
        idle(5'd6);
        // x0: WB to x0, MD to x0 and issue to x0 all in one cycle.
        apply_cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) random_cycle(65);

        // Mid-operation reset while the hold buffer is occupied and x9 pending.
        apply_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        for (int i = 0; i < 2000 && !m_hold_v; i++) random_cycle(95);
        check("hold_reached", 32'(m_hold_v), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        bus.WB_VALID = 1'b0;
        bus.MD_VALID = 1'b0;
        bus.MD_ISSUE = 1'b0;
        bus.RS1_ADDRESS = 5'd9;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge CLK);
        RESET = 1'b1;
        idle(5'd9);

        for (int i = 0; i < 500; i++) random_cycle(65);
        for (int i = 0; i < 30; i++) idle(5'($urandom_range(0, 31)));
        @(negedge CLK);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
